// File: rtl/cu_pkg.sv
// cu_pkg: shared types and constants for the LEGv8 control-unit sequencer
package cu_pkg;
    localparam int CW_WIDTH     = 33;
    localparam int NUM_CLASSES  = 8;
    localparam int MAX_EXEC_DEF = 4;

    localparam int CW_ALU_EN    = 32;
    localparam int CW_ALU_BS    = 31;
    localparam int CW_ALU_FS    = 26;
    localparam int CW_RF_B_EN   = 25;
    localparam int CW_RF_SA     = 20;
    localparam int CW_RF_SB     = 15;
    localparam int CW_RF_DA     = 10;
    localparam int CW_RF_W      = 9;
    localparam int CW_RAM_EN    = 8;
    localparam int CW_RAM_W     = 7;
    localparam int CW_PC_EN     = 6;
    localparam int CW_PC_FS     = 4;
    localparam int CW_PC_IS     = 3;
    localparam int CW_STATUS_LD = 2;
    localparam int CW_NS        = 0;

    localparam logic [CW_WIDTH-3:0] CW_NOP = '0;

    typedef enum logic [2:0] {
        CLS_RALU, CLS_IALU, CLS_D, CLS_B, CLS_CB, CLS_BCOND, CLS_MOV, CLS_ILLEGAL
    } cls_e;

    typedef enum logic [1:0] {S_IDLE, S_FETCH, S_EXEC, S_HALT} fsm_e;

    localparam logic [10:0] OP_ADD   = 11'b10001011000;
    localparam logic [10:0] OP_SUB   = 11'b11001011000;
    localparam logic [10:0] OP_AND   = 11'b10001010000;
    localparam logic [10:0] OP_ORR   = 11'b10101010000;
    localparam logic [10:0] OP_EOR   = 11'b11001010000;
    localparam logic [9:0]  OP_ADDI  = 10'b1001000100;
    localparam logic [9:0]  OP_SUBI  = 10'b1101000100;
    localparam logic [9:0]  OP_ANDI  = 10'b1001001000;
    localparam logic [9:0]  OP_ORRI  = 10'b1011001000;
    localparam logic [9:0]  OP_EORI  = 10'b1101001000;
    localparam logic [10:0] OP_LDUR  = 11'b11111000010;
    localparam logic [10:0] OP_STUR  = 11'b11111000000;
    localparam logic [5:0]  OP_B     = 6'b000101;
    localparam logic [7:0]  OP_CBZ   = 8'b10110100;
    localparam logic [7:0]  OP_CBNZ  = 8'b10110101;
    localparam logic [7:0]  OP_BCOND = 8'b01010100;
    localparam logic [8:0]  OP_MOVZ  = 9'b110100101;
    localparam logic [8:0]  OP_MOVK  = 9'b111100101;
endpackage

// File: rtl/cu_sequencer_if.sv
// cu_sequencer_if: fetch/decoder/datapath signal bundle around the sequencer
interface cu_sequencer_if;
    import cu_pkg::*;
    logic                            run;
    logic                            mem_ready;
    logic [31:0]                     instr_in;
    logic [NUM_CLASSES*CW_WIDTH-1:0] cw_class;
    logic [31:0]                     ir;
    logic [1:0]                      state;
    logic [CW_WIDTH-3:0]             cw_out;
    logic                            fetch;
    logic                            ir_load;
    logic                            illegal;
    logic                            halted;
    logic [31:0]                     instr_count;

    modport master (
        input  run, mem_ready, instr_in, cw_class,
        output ir, state, cw_out, fetch, ir_load, illegal, halted, instr_count
    );
    modport slave (
        output run, mem_ready, instr_in, cw_class,
        input  ir, state, cw_out, fetch, ir_load, illegal, halted, instr_count
    );
endinterface

// File: rtl/legv8_opcode_class.sv
// legv8_opcode_class: maps the top 11 opcode bits to a decoder class, first match wins
module legv8_opcode_class
    import cu_pkg::*;
(
    input  logic [10:0] op_i,
    output cls_e        cls_o
);
    // Priority chain mirrors the class numbering so earlier classes shadow later ones
    always_comb begin
        cls_o = (op_i inside {OP_ADD, OP_SUB, OP_AND, OP_ORR, OP_EOR})            ? CLS_RALU  :
                (op_i[10:1] inside {OP_ADDI, OP_SUBI, OP_ANDI, OP_ORRI, OP_EORI}) ? CLS_IALU  :
                (op_i inside {OP_LDUR, OP_STUR})                                  ? CLS_D     :
                (op_i[10:5] == OP_B)                                              ? CLS_B     :
                (op_i[10:3] inside {OP_CBZ, OP_CBNZ})                             ? CLS_CB    :
                (op_i[10:3] == OP_BCOND)                                          ? CLS_BCOND :
                (op_i[10:2] inside {OP_MOVZ, OP_MOVK})                            ? CLS_MOV   :
                                                                                    CLS_ILLEGAL;
    end
endmodule

// File: rtl/cu_sequencer.sv
// cu_sequencer: fetch/execute sequencer selecting the active decoder control word
module cu_sequencer
    import cu_pkg::*;
#(
    parameter int MAX_EXEC = MAX_EXEC_DEF
) (
    input  logic           clock,
    input  logic           reset_n,
    cu_sequencer_if.master bus
);
    localparam int               CNT_W    = $clog2(MAX_EXEC + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_EXEC - 1);

    fsm_e                fsm_q;
    logic [31:0]         ir_q;
    logic [1:0]          state_q;
    logic [CNT_W-1:0]    cnt_q;
    logic                illegal_q;
    logic [31:0]         retired_q;
    cls_e                cls;
    logic [CW_WIDTH-1:0] cw_sel;
    logic [1:0]          next_state;
    logic                exec_legal;

    legv8_opcode_class u_class (
        .op_i  (ir_q[31:21]),
        .cls_o (cls)
    );

    assign cw_sel     = bus.cw_class[int'(cls)*CW_WIDTH +: CW_WIDTH];
    assign next_state = cw_sel[CW_NS +: 2];
    assign exec_legal = (fsm_q == S_EXEC) && (cls != CLS_ILLEGAL);

    assign bus.ir          = ir_q;
    assign bus.state       = state_q;
    assign bus.cw_out      = exec_legal ? cw_sel[CW_WIDTH-1:CW_STATUS_LD] : CW_NOP;
    assign bus.fetch       = (fsm_q == S_FETCH);
    assign bus.ir_load     = (fsm_q == S_FETCH) && bus.mem_ready;
    assign bus.illegal     = illegal_q;
    assign bus.halted      = (fsm_q == S_HALT);
    assign bus.instr_count = retired_q;

    // Sequencer FSM: fetch handshake, multi-cycle execute tracking, retire count and traps
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            fsm_q     <= S_IDLE;
            ir_q      <= '0;
            state_q   <= '0;
            cnt_q     <= '0;
            illegal_q <= 1'b0;
            retired_q <= '0;
        end else begin
            case (fsm_q)
                S_IDLE: if (bus.run) fsm_q <= S_FETCH;
                S_FETCH: begin
                    if (bus.mem_ready) begin
                        ir_q    <= bus.instr_in;
                        state_q <= '0;
                        cnt_q   <= '0;
                        fsm_q   <= S_EXEC;
                    end else if (!bus.run) begin
                        fsm_q <= S_IDLE;
                    end
                end
                S_EXEC: begin
                    if (cls == CLS_ILLEGAL || (next_state != 2'd0 && cnt_q == CNT_LAST)) begin
                        illegal_q <= 1'b1;
                        fsm_q     <= S_HALT;
                    end else if (next_state == 2'd0) begin
                        retired_q <= retired_q + 32'd1;
                        fsm_q     <= bus.run ? S_FETCH : S_IDLE;
                    end else begin
                        state_q <= next_state;
                        cnt_q   <= cnt_q + 1'b1;
                    end
                end
                S_HALT: fsm_q <= S_HALT;
            endcase
        end
    end
endmodule

// File: tb/tb_cu_sequencer.sv
// tb_cu_sequencer: directed self-checking bench for the sequencer and opcode classifier
module tb_cu_sequencer;
    import cu_pkg::*;

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    cu_sequencer_if bus();
    cu_sequencer dut (
        .clock   (clk),
        .reset_n (reset_n),
        .bus     (bus.master)
    );

    logic [10:0] u_op;
    cls_e        u_cls;
    legv8_opcode_class u_unit (
        .op_i  (u_op),
        .cls_o (u_cls)
    );

    // Decoder model: each class supplies one cw in state 0 and another in later states
    logic [CW_WIDTH-1:0] cw0 [NUM_CLASSES];
    logic [CW_WIDTH-1:0] cw1 [NUM_CLASSES];
    always_comb begin
        bus.cw_class = '0;
        for (int k = 0; k < NUM_CLASSES; k++)
            bus.cw_class[k*CW_WIDTH +: CW_WIDTH] = (bus.state == 2'd0) ? cw0[k] : cw1[k];
    end

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    logic [10:0] op_tab  [10] = '{11'b10001011000, 11'b11001011000, 11'b10101010000,
                                  11'b10010001000, 11'b11111000010, 11'b00010111111,
                                  11'b10110101001, 11'b01010100000, 11'b11110010110,
                                  11'b00000000000};
    logic [2:0]  cls_tab [10] = '{3'd0, 3'd0, 3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7};

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n       = 1'b0;
        bus.run       = 1'b0;
        bus.mem_ready = 1'b0;
        bus.instr_in  = '0;
        for (int k = 0; k < NUM_CLASSES; k++) begin
            cw0[k] = '0;
            cw1[k] = '0;
        end
        cw0[6] = {31'h0ABC_DEF1, 2'b00};
        cw1[6] = {31'h0ABC_DEF1, 2'b00};
        cw0[2] = {31'h1111_2222, 2'b01};
        cw1[2] = {31'h3333_4444, 2'b00};
        cw0[0] = {31'h5555_0000, 2'b01};
        cw1[0] = {31'h6666_0000, 2'b01};
        cw0[7] = '1;
        cw1[7] = '1;

        for (int i = 0; i < 10; i++) begin
            u_op = op_tab[i];
            #1;
            check($sformatf("class[%0d]", i), u_cls, cls_tab[i]);
        end

        tick(2);
        check("rst_ir", bus.ir, 0);
        check("rst_state", bus.state, 0);
        check("rst_cw", bus.cw_out, 0);
        check("rst_fetch", bus.fetch, 0);
        check("rst_irload", bus.ir_load, 0);
        check("rst_illegal", bus.illegal, 0);
        check("rst_halted", bus.halted, 0);
        check("rst_count", bus.instr_count, 0);

        reset_n = 1'b1;
        tick(2);
        check("idle_fetch", bus.fetch, 0);
        check("idle_cw", bus.cw_out, 0);

        bus.instr_in  = 32'hD280_0021;
        bus.mem_ready = 1'b1;
        bus.run       = 1'b1;
        tick();
        check("movz_fetch", bus.fetch, 1);
        check("movz_irload", bus.ir_load, 1);
        check("movz_ir_old", bus.ir, 0);
        check("movz_fetch_cw", bus.cw_out, 0);
        tick();
        check("movz_ir", bus.ir, 32'hD280_0021);
        check("movz_state", bus.state, 0);
        check("movz_cw", bus.cw_out, 31'h0ABC_DEF1);
        check("movz_exec_fetch", bus.fetch, 0);
        check("movz_count0", bus.instr_count, 0);
        bus.mem_ready = 1'b0;
        bus.instr_in  = 32'hF840_0020;
        tick();
        check("movz_count1", bus.instr_count, 1);
        check("movz_refetch", bus.fetch, 1);
        check("movz_after_cw", bus.cw_out, 0);
        check("wait_irload0", bus.ir_load, 0);
        for (int i = 0; i < 2; i++) begin
            tick();
            check("wait_fetch", bus.fetch, 1);
            check("wait_irload", bus.ir_load, 0);
            check("wait_ir", bus.ir, 32'hD280_0021);
        end
        bus.mem_ready = 1'b1;
        #1;
        check("ldur_irload", bus.ir_load, 1);
        tick();
        bus.mem_ready = 1'b0;
        #1;
        check("ldur_ir", bus.ir, 32'hF840_0020);
        check("ldur_state0", bus.state, 0);
        check("ldur_cw0", bus.cw_out, 31'h1111_2222);
        tick();
        check("ldur_state1", bus.state, 1);
        check("ldur_cw1", bus.cw_out, 31'h3333_4444);
        check("ldur_count_mid", bus.instr_count, 1);
        tick();
        check("ldur_count", bus.instr_count, 2);
        check("ldur_refetch", bus.fetch, 1);

        bus.run = 1'b0;
        tick();
        check("abort_fetch", bus.fetch, 0);
        check("abort_ir", bus.ir, 32'hF840_0020);
        check("abort_cw", bus.cw_out, 0);

        bus.run       = 1'b1;
        bus.mem_ready = 1'b1;
        tick(2);
        bus.run       = 1'b0;
        bus.mem_ready = 1'b0;
        #1;
        check("stop_cw0", bus.cw_out, 31'h1111_2222);
        tick();
        check("stop_state1", bus.state, 1);
        tick();
        check("stop_count", bus.instr_count, 3);
        check("stop_idle_fetch", bus.fetch, 0);
        check("stop_idle_cw", bus.cw_out, 0);
        tick();
        check("stop_stay_idle", bus.fetch, 0);

        bus.instr_in  = 32'h8B00_0000;
        bus.run       = 1'b1;
        bus.mem_ready = 1'b1;
        tick(2);
        bus.mem_ready = 1'b0;
        #1;
        for (int i = 0; i < 4; i++) begin
            check($sformatf("runaway_halted[%0d]", i), bus.halted, 0);
            check($sformatf("runaway_cw[%0d]", i), bus.cw_out, (i == 0) ? 31'h5555_0000 : 31'h6666_0000);
            tick();
        end
        check("runaway_illegal", bus.illegal, 1);
        check("runaway_halted", bus.halted, 1);
        check("runaway_cw", bus.cw_out, 0);
        check("runaway_fetch", bus.fetch, 0);
        check("runaway_count", bus.instr_count, 3);

        reset_n = 1'b0;
        #1;
        check("clr_illegal", bus.illegal, 0);
        check("clr_halted", bus.halted, 0);
        check("clr_count", bus.instr_count, 0);
        reset_n       = 1'b1;
        bus.instr_in  = 32'h0000_0000;
        bus.run       = 1'b1;
        bus.mem_ready = 1'b1;
        tick(2);
        bus.mem_ready = 1'b0;
        #1;
        check("ill_exec_cw", bus.cw_out, 0);
        tick();
        check("ill_illegal", bus.illegal, 1);
        check("ill_halted", bus.halted, 1);
        check("ill_fetch", bus.fetch, 0);
        check("ill_count", bus.instr_count, 0);
        bus.run = 1'b0;
        tick();
        bus.run = 1'b1;
        tick(2);
        check("ill_stuck_halted", bus.halted, 1);
        check("ill_stuck_fetch", bus.fetch, 0);
        check("ill_stuck_illegal", bus.illegal, 1);

        reset_n = 1'b0;
        #1;
        reset_n       = 1'b1;
        bus.instr_in  = 32'hF840_0020;
        bus.mem_ready = 1'b1;
        tick(2);
        bus.mem_ready = 1'b0;
        tick();
        check("mid_state1", bus.state, 1);
        #2;
        reset_n = 1'b0;
        #1;
        check("mid_rst_ir", bus.ir, 0);
        check("mid_rst_state", bus.state, 0);
        check("mid_rst_cw", bus.cw_out, 0);
        check("mid_rst_fetch", bus.fetch, 0);
        check("mid_rst_count", bus.instr_count, 0);
        tick();
        check("mid_hold_fetch", bus.fetch, 0);
        bus.run = 1'b0;
        reset_n = 1'b1;
        tick(2);
        check("post_rst_fetch", bus.fetch, 0);
        check("post_rst_cw", bus.cw_out, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
